stack_key_ctrl: RTL and testbench

Input stage that sits directly upstream of the 8-deep, 4-bit push/pop stack. It turns two raw board push-buttons and four data switches into clean, single-cycle `push`/`pop` strobes with aligned `data_in`. It synchronizes and debounces the buttons, arbitrates simultaneous presses, and uses the stack's `full`/`empty` flags to block illegal operations and count them.

---
 rtl/stack_key_ctrl.sv | 95 +++++++++
 tb/tb_stack_key_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_key_ctrl.sv
// Button front end for the 8-deep stack: two-flop sync, per-key debounce, push/pop arbitration gated by full/empty.
// Strobes and err fire DB_CYCLES+2 edges after a key is first sampled low; rejected presses are counted (saturating at 15).
module stack_key_ctrl #(
    parameter int DB_CYCLES = 500000,
    parameter int W         = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_push_n,
    input  logic         key_pop_n,
    input  logic [W-1:0] sw,
    input  logic         full,
    input  logic         empty,
    output logic         push,
    output logic         pop,
    output logic [W-1:0] data_out,
    output logic         err,
    output logic [3:0]   err_cnt
);

    localparam int            CW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    // Bit 0 is the push key, bit 1 the pop key.
    logic [1:0]   r_key_s1;
    logic [1:0]   r_key_s2;
    logic [W-1:0] r_sw_s1;
    logic [W-1:0] r_sw_s2;
    logic [1:0]   w_fall;
    logic         w_push_ok;
    logic         w_pop_ok;
    logic         w_rej;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_s1 <= 2'b11;
            r_key_s2 <= 2'b11;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= {key_pop_n, key_push_n};
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_db
        logic          r_stb;
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_stb <= 1'b1;
                r_cnt <= '0;
            end else if (r_key_s2[k] == r_stb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stb <= r_key_s2[k];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        // Press is decided in the same cycle stb is about to fall, so the strobe lands on that edge.
        assign w_fall[k] = r_stb & ~r_key_s2[k] & (r_cnt == CNT_MAX);
    end

    // Simultaneous press: push wins, the pop is always dropped and counted once.
    assign w_push_ok = w_fall[0] & ~full;
    assign w_pop_ok  = w_fall[1] & ~w_fall[0] & ~empty;
    assign w_rej     = (w_fall[0] & full) | (w_fall[1] & (w_fall[0] | empty));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push     <= 1'b0;
            pop      <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
            err_cnt  <= 4'd0;
        end else begin
            push <= w_push_ok;
            pop  <= w_pop_ok;
            err  <= w_rej;
            if (w_push_ok) begin
                data_out <= r_sw_s2;
            end
            if (w_rej && (err_cnt != 4'hF)) begin
                err_cnt <= err_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_stack_key_ctrl.sv
// Bench for stack_key_ctrl with DB_CYCLES=4 driving a behavioural 8-deep stack.
module tb_stack_key_ctrl;

    logic       clk;
    logic       rst;
    logic       key_push_n;
    logic       key_pop_n;
    logic [3:0] sw;
    logic       push;
    logic       pop;
    logic [3:0] data_out;
    logic       err;
    logic [3:0] err_cnt;

    // Downstream stack: 8 deep, registered flags.
    logic [3:0] stk_mem [8];
    logic [3:0] stk_cnt;
    logic       stk_full;
    logic       stk_empty;
    logic [3:0] stk_dout;

    stack_key_ctrl #(.DB_CYCLES(4), .W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_push_n (key_push_n),
        .key_pop_n  (key_pop_n),
        .sw         (sw),
        .full       (stk_full),
        .empty      (stk_empty),
        .push       (push),
        .pop        (pop),
        .data_out   (data_out),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk_cnt   <= 4'd0;
            stk_full  <= 1'b0;
            stk_empty <= 1'b1;
            stk_dout  <= 4'd0;
        end else if (push && !stk_full) begin
            stk_mem[stk_cnt[2:0]] <= data_out;
            stk_cnt   <= stk_cnt + 4'd1;
            stk_full  <= (stk_cnt == 4'd7);
            stk_empty <= 1'b0;
        end else if (pop && !stk_empty) begin
            stk_dout  <= stk_mem[3'(stk_cnt - 4'd1)];
            stk_cnt   <= stk_cnt - 4'd1;
            stk_empty <= (stk_cnt == 4'd1);
            stk_full  <= 1'b0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       push;
        logic       pop;
        logic       err;
        logic [3:0] data;
        logic [3:0] cnt;
        logic [3:0] val;
        int         cyc;
    } exp_t;

    exp_t       sb_q [$];
    int         n_total = 0;
    int         n_pass  = 0;
    int         n_fail  = 0;

    // Reference state for expectations.
    logic [3:0] mdl_mem [8];
    int         depth    = 0;
    int         exp_cnt  = 0;
    logic [3:0] exp_data = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Every strobe/err cycle pops one expectation; a pop also checks the stack's output one cycle later.
    exp_t       mon_e;
    logic       pend_pop = 1'b0;
    logic [3:0] pend_val = 4'd0;
    always @(negedge clk) begin
        if (pend_pop) begin
            check("stack_dout", {28'd0, stk_dout}, {28'd0, pend_val});
            pend_pop = 1'b0;
        end
        if (rst && (push || pop || err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_event", {29'd0, push, pop, err}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("event_cycle", cyc, mon_e.cyc);
                check("push", {31'd0, push}, {31'd0, mon_e.push});
                check("pop", {31'd0, pop}, {31'd0, mon_e.pop});
                check("err", {31'd0, err}, {31'd0, mon_e.err});
                check("data_out", {28'd0, data_out}, {28'd0, mon_e.data});
                check("err_cnt", {28'd0, err_cnt}, {28'd0, mon_e.cnt});
                if (mon_e.pop) begin
                    pend_pop = 1'b1;
                    pend_val = mon_e.val;
                end
            end
        end
    end

    task automatic press(input bit do_push, input bit do_pop, input logic [3:0] s, input int hold);
        exp_t e;
        bit   p_ok;
        bit   q_ok;
        bit   rej;
        sw = s;
        repeat (3) @(negedge clk);
        p_ok = do_push && (depth < 8);
        q_ok = do_pop && !do_push && (depth > 0);
        rej  = (do_push && depth == 8) || (do_pop && (do_push || depth == 0));
        if (p_ok) begin
            exp_data       = s;
            mdl_mem[depth] = s;
            depth++;
        end
        if (q_ok) depth--;
        if (rej && exp_cnt != 15) exp_cnt++;
        e.push = p_ok;
        e.pop  = q_ok;
        e.err  = rej;
        e.data = exp_data;
        e.cnt  = exp_cnt[3:0];
        e.val  = q_ok ? mdl_mem[depth] : 4'd0;
        e.cyc  = cyc + 6;
        sb_q.push_back(e);
        key_push_n = !do_push;
        key_pop_n  = !do_pop;
        repeat (hold) @(negedge clk);
        key_push_n = 1'b1;
        key_pop_n  = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst        = 1'b0;
        key_push_n = 1'b1;
        key_pop_n  = 1'b1;
        sw         = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_push", {31'd0, push}, 32'd0);
        check("rst_pop", {31'd0, pop}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_data_out", {28'd0, data_out}, 32'd0);
        check("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single push held for 20 cycles.
        press(1'b1, 1'b0, 4'hA, 20);
        check("t1_empty", {31'd0, stk_empty}, 32'd0);

        // Bouncing pop key: runs of 2 never survive the debounce.
        for (int i = 0; i < 15; i++) begin
            key_pop_n = ~key_pop_n;
            repeat (2) @(negedge clk);
        end
        key_pop_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t2_err_cnt", {28'd0, err_cnt}, 32'd0);

        // Drain the entry from step 1, then fill and overflow.
        press(1'b0, 1'b1, 4'h0, 10);
        for (int i = 0; i < 8; i++) press(1'b1, 1'b0, 4'(i), 10);
        check("t3_full", {31'd0, stk_full}, 32'd1);
        press(1'b1, 1'b0, 4'hF, 10);
        check("t3_err_cnt", {28'd0, err_cnt}, 32'd1);

        // Drain (7..0) and underflow.
        for (int i = 0; i < 8; i++) press(1'b0, 1'b1, 4'h0, 10);
        check("t4_empty", {31'd0, stk_empty}, 32'd1);
        press(1'b0, 1'b1, 4'h0, 10);
        check("t4_err_cnt", {28'd0, err_cnt}, 32'd2);

        // Simultaneous press with one entry stored.
        press(1'b1, 1'b0, 4'h5, 10);
        press(1'b1, 1'b1, 4'h9, 10);
        check("t5_depth", {28'd0, stk_cnt}, 32'd2);
        check("t5_err_cnt", {28'd0, err_cnt}, 32'd3);

        // Empty the stack, then saturate the error counter.
        press(1'b0, 1'b1, 4'h0, 10);
        press(1'b0, 1'b1, 4'h0, 10);
        for (int i = 0; i < 20; i++) press(1'b0, 1'b1, 4'h0, 8);
        check("t6_err_cnt_sat", {28'd0, err_cnt}, 32'd15);

        // Reset two cycles into a push debounce, key held through release.
        sw = 4'hC;
        repeat (3) @(negedge clk);
        key_push_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_push", {31'd0, push}, 32'd0);
        check("t6_rst_pop", {31'd0, pop}, 32'd0);
        check("t6_rst_err", {31'd0, err}, 32'd0);
        check("t6_rst_data_out", {28'd0, data_out}, 32'd0);
        check("t6_rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        depth    = 0;
        exp_cnt  = 0;
        exp_data = 4'd0;
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        exp_data  = 4'hC;
        e.push    = 1'b1;
        e.pop     = 1'b0;
        e.err     = 1'b0;
        e.data    = 4'hC;
        e.cnt     = 4'd0;
        e.val     = 4'd0;
        e.cyc     = cyc + 6;
        sb_q.push_back(e);
        depth     = 1;
        repeat (20) @(negedge clk);
        key_push_n = 1'b1;
        repeat (15) @(negedge clk);
        check("t6_depth", {28'd0, stk_cnt}, 32'd1);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
